// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multicycle ALU with restoring divider and valid/ready handshake
// Single-cycle ops finish on the accept edge; DIV/MOD run one quotient bit per cycle.
module alu_multicycle #(
  parameter int BITS_DATA = 32,
  parameter int DIV_STEPS = BITS_DATA
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           opcode,
  input  logic [BITS_DATA-1:0] operando_a,
  input  logic [BITS_DATA-1:0] operando_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS_DATA-1:0] resultado,
  output logic                 C,
  output logic                 S,
  output logic                 O,
  output logic                 Z,
  output logic                 err
);

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_HLT = 5'd1;
  localparam logic [4:0] OP_NOT = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;
  localparam logic [4:0] OP_NEG = 5'd6;
  localparam logic [4:0] OP_ADD = 5'd7;
  localparam logic [4:0] OP_SUB = 5'd8;
  localparam logic [4:0] OP_MUL = 5'd9;
  localparam logic [4:0] OP_DIV = 5'd10;
  localparam logic [4:0] OP_MOD = 5'd11;

  localparam int CW = $clog2(DIV_STEPS + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(DIV_STEPS - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DIV = 2'd1, ST_DONE = 2'd2} state_t;

  state_t state_q, state_d;
  logic [BITS_DATA-1:0] res_q, res_d;
  logic                 c_q, c_d, s_q, s_d, o_q, o_d, z_q, z_d, err_q, err_d;
  logic [BITS_DATA-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic                 is_mod_q, is_mod_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                   accept, is_div_op, div_by_zero, rem_ge;
  logic [BITS_DATA:0]     rem_sh, add_full;
  logic [BITS_DATA-1:0]   rem_step, quo_step, sub_res;
  logic [2*BITS_DATA-1:0] prod;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh   = {rem_q, quo_q[BITS_DATA-1]};
    rem_ge   = rem_sh >= {1'b0, dvs_q};
    rem_step = rem_ge ? BITS_DATA'(rem_sh - {1'b0, dvs_q}) : rem_sh[BITS_DATA-1:0];
    quo_step = {quo_q[BITS_DATA-2:0], rem_ge};
  end

  always_comb begin
    accept      = in_valid && (state_q == ST_IDLE);
    is_div_op   = (opcode == OP_DIV) || (opcode == OP_MOD);
    div_by_zero = (operando_b == '0);
    add_full    = {1'b0, operando_a} + {1'b0, operando_b};
    sub_res     = operando_a - operando_b;
    prod        = {{BITS_DATA{1'b0}}, operando_a} * {{BITS_DATA{1'b0}}, operando_b};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (is_div_op && !div_by_zero) ? ST_DIV : ST_DONE;
      ST_DIV:  if (cnt_q == LAST_STEP) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    res_d    = res_q;
    c_d      = c_q;
    o_d      = o_q;
    err_d    = err_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    is_mod_d = is_mod_q;
    cnt_d    = cnt_q;
    if (accept) begin
      res_d = '0;
      c_d   = 1'b0;
      o_d   = 1'b0;
      err_d = 1'b0;
      case (opcode)
        OP_NOP, OP_HLT: res_d = '0;
        OP_NOT: res_d = ~operando_a;
        OP_AND: res_d = operando_a & operando_b;
        OP_OR:  res_d = operando_a | operando_b;
        OP_XOR: res_d = operando_a ^ operando_b;
        OP_NEG: begin
          res_d = '0 - operando_a;
          c_d   = (operando_a != '0);
          o_d   = (operando_a == {1'b1, {(BITS_DATA-1){1'b0}}});
        end
        OP_ADD: begin
          {c_d, res_d} = add_full;
          o_d = (operando_a[BITS_DATA-1] == operando_b[BITS_DATA-1]) &&
                (add_full[BITS_DATA-1] != operando_a[BITS_DATA-1]);
        end
        OP_SUB: begin
          res_d = sub_res;
          c_d   = (operando_a < operando_b);
          o_d   = (operando_a[BITS_DATA-1] != operando_b[BITS_DATA-1]) &&
                  (sub_res[BITS_DATA-1] != operando_a[BITS_DATA-1]);
        end
        OP_MUL: begin
          res_d = prod[BITS_DATA-1:0];
          o_d   = |prod[2*BITS_DATA-1:BITS_DATA];
        end
        OP_DIV, OP_MOD: begin
          if (div_by_zero) begin
            res_d = (opcode == OP_DIV) ? '1 : operando_a;
            err_d = 1'b1;
          end else begin
            quo_d    = operando_a;
            rem_d    = '0;
            dvs_d    = operando_b;
            is_mod_d = (opcode == OP_MOD);
            cnt_d    = '0;
          end
        end
        default: err_d = 1'b1;
      endcase
    end else if (state_q == ST_DIV) begin
      quo_d = quo_step;
      rem_d = rem_step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_STEP) res_d = is_mod_q ? rem_step : quo_step;
    end
    s_d = res_d[BITS_DATA-1];
    z_d = (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      res_q    <= '0;
      c_q      <= 1'b0;
      s_q      <= 1'b0;
      o_q      <= 1'b0;
      z_q      <= 1'b1;
      err_q    <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      is_mod_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      c_q      <= c_d;
      s_q      <= s_d;
      o_q      <= o_d;
      z_q      <= z_d;
      err_q    <= err_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      is_mod_q <= is_mod_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    resultado = res_q;
    C         = c_q;
    S         = s_q;
    O         = o_q;
    Z         = z_q;
    err       = err_q;
  end

endmodule
